ca_stepper: RTL and testbench
=============================

# ca_stepper

Upstream stimulus stage for `cycle_chk`: an 8-cell elementary cellular automaton that advances one generation per clock and drives its state onto `cycle_chk.stage0`. It takes a seed and an 8-bit Wolfram rule, steps while running, and stops when one of three things happens:
- the downstream checker reports a repeat, via its `cycle` output wired back in;
- a step limit is reached;
- software issues `stop`.

## Interface

Parameters:
- WIDTH, 8, number of cells; must match `cycle_chk` data width.
- MAX_STEPS, 255, step limit before timeout; 1..2^CNT_W-1.
- CNT_W, 8, step counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse; capture `seed` and `rule`, clear counters.
- seed  in  WIDTH  initial generation.
- rule  in  8  Wolfram rule number.
- start  in  1  one-cycle pulse; begin or resume stepping from IDLE.
- stop  in  1  one-cycle pulse; pause stepping, return to IDLE.
- cycle_in  in  1  from `cycle_chk.cycle`.
- state_out  out  WIDTH  current generation; wired to `cycle_chk.stage0`.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- done_cycle  out  1  DONE entered via `cycle_in`.
- done_timeout  out  1  DONE entered via step limit.
- steps  out  CNT_W  generations computed since last load.

## Operation

- Next-state rule, per cell i: `next[i] = rule_q[{s[(i+1)%W], s[i], s[(i-1+W)%W]}]`.
  - Index bit 2 is the left neighbour (i+1); index bit 0 is the right neighbour (i-1).
  - Boundaries wrap around: cell W-1 and cell 0 are neighbours.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `start` → RUN.
  - `state_out` holds.
- RUN, on each edge:
  - `state_out <= next`;
  - `steps <= steps+1`.
- RUN exit conditions, evaluated on pre-edge values. When an exit fires, that edge performs no update.
  - `stop` → IDLE.
  - Else if `cycle_in` && `steps >= 3` → DONE, set `done_cycle`.
  - Else if `steps == MAX_STEPS` → DONE, set `done_timeout`.
- The `steps >= 3` gate masks `cycle_chk` pipeline fill after a load.
- DONE:
  - holds all outputs;
  - ignores `start`, `stop` and `cycle_in`;
  - leaves only via `load`.
- `load` (any state, highest priority):
  - `state_out <= seed`, `rule_q <= rule`;
  - `steps <= 0`;
  - clear both done flags;
  - FSM → IDLE.
- Priority order: load > stop > cycle > timeout > start.
  - `start` together with `stop` in IDLE: stay IDLE.
- `steps` never wraps; MAX_STEPS bounds it.

## Timing

- Reset values:
  - `state_out` = 0, `rule_q` = 0, `steps` = 0;
  - FSM = IDLE;
  - `busy`, `done`, `done_cycle`, `done_timeout` = 0.
- All outputs are registered or decoded directly from the FSM register. There is no combinational path from inputs to outputs.
- Latency:
  - `load` → `state_out` = seed on the next edge.
  - `start` → `busy` on the next edge; first new generation one edge after that.
- Reset asserted mid-RUN: immediate return to reset values; the rule is lost and must be reloaded.
- `rule` and `seed` are sampled only on the `load` edge.

## Structure

- Package `ca_pkg`:
  - FSM state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - WIDTH default;
  - CHK_FILL constant = 3.
- Sub-module `ca_next_state`: purely combinational; `s[WIDTH-1:0]`, `rule[7:0]` → `next[WIDTH-1:0]`; contains the wrap-around neighbour indexing.
- Top level: FSM, counter, registers, done-flag logic.

## Test plan

- Identity: load seed=0x5A, rule=0xCC (204); start; `cycle_in` held 0.
  - `state_out` stays 0x5A.
  - `steps` increments 1,2,3…
- Rotate/timeout: MAX_STEPS=20; load seed=0x01, rule=0xAA (170); start.
  - `state_out` sequence 0x02, 0x04, …, 0x80, 0x01 (wraps).
  - After 20 generations: `done_timeout`=1, `steps`=20, `busy`=0.
- Cycle exit: load seed=0x5A, rule=0x33 (51); start with `cycle_in` held 1.
  - `state_out` alternates 0xA5/0x5A.
  - DONE on the 4th edge after start is accepted.
  - `done_cycle`=1, `steps`=3, `done_timeout`=0.
- Stop/resume: rule=0xCC; start; stop at `steps`=5.
  - IDLE with `steps`=5 held.
  - Start again → continues from 6.
  - Simultaneous start+stop in IDLE → stays IDLE.
- Priority and reset:
  - In RUN, pulse `load` with `cycle_in`=1 and `stop`=1 → IDLE, `steps`=0, new seed.
  - Drop `n_reset` mid-RUN → all outputs 0 asynchronously, before the next edge.
- Closed loop: instantiate `cycle_chk` on `state_out`; seed=0x00, rule=0x00.
  - Fixed point.
  - Run ends with `done_cycle`=1 and `steps` ≤ 5.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton stimulus stepper.
// Imported by the next-state logic and the stepper top level.
package ca_pkg;

    localparam int CA_WIDTH = 8;

    // Generations that must elapse after a load before a repeat report from
    // the downstream checker is trusted (its pipeline is still filling).
    localparam int CHK_FILL = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ca_state_t;

endpackage

// File: rtl/ca_next_state.sv
// Combinational elementary-CA generation step with wrap-around neighbours.
// Rule index per cell is {left (i+1), self, right (i-1)}.
module ca_next_state
    import ca_pkg::*;
#(
    parameter int WIDTH = CA_WIDTH
) (
    input  logic [WIDTH-1:0] s,
    input  logic [7:0]       rule,
    output logic [WIDTH-1:0] next
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            localparam int LP_L = (gi + 1) % WIDTH;
            localparam int LP_R = (gi + WIDTH - 1) % WIDTH;
            logic [2:0] w_idx;
            assign w_idx    = {s[LP_L], s[gi], s[LP_R]};
            assign next[gi] = rule[w_idx];
        end
    endgenerate

endmodule

// File: rtl/ca_stepper.sv
// 8-cell elementary CA stepper feeding the cycle checker: one generation per
// clock while running; stops on checker repeat, step limit or software stop.
module ca_stepper
    import ca_pkg::*;
#(
    parameter int WIDTH     = CA_WIDTH,
    parameter int MAX_STEPS = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       rule,
    input  logic             start,
    input  logic             stop,
    input  logic             cycle_in,
    output logic [WIDTH-1:0] state_out,
    output logic             busy,
    output logic             done,
    output logic             done_cycle,
    output logic             done_timeout,
    output logic [CNT_W-1:0] steps
);

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] LP_FILL = CNT_W'(CHK_FILL);

    ca_state_t        r_state;
    logic [WIDTH-1:0] r_gen;
    logic [7:0]       r_rule;
    logic [CNT_W-1:0] r_steps;
    logic             r_done_cycle;
    logic             r_done_timeout;
    logic [WIDTH-1:0] w_next;

    ca_next_state #(.WIDTH(WIDTH)) u_next (
        .s    (r_gen),
        .rule (r_rule),
        .next (w_next)
    );

    // Exits in RUN take the edge without stepping, so steps never passes LP_MAX.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state        <= ST_IDLE;
            r_gen          <= '0;
            r_rule         <= '0;
            r_steps        <= '0;
            r_done_cycle   <= 1'b0;
            r_done_timeout <= 1'b0;
        end else if (load) begin
            r_state        <= ST_IDLE;
            r_gen          <= seed;
            r_rule         <= rule;
            r_steps        <= '0;
            r_done_cycle   <= 1'b0;
            r_done_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (cycle_in && (r_steps >= LP_FILL)) begin
                        r_state      <= ST_DONE;
                        r_done_cycle <= 1'b1;
                    end else if (r_steps == LP_MAX) begin
                        r_state        <= ST_DONE;
                        r_done_timeout <= 1'b1;
                    end else begin
                        r_gen   <= w_next;
                        r_steps <= r_steps + CNT_W'(1);
                    end
                end
                ST_DONE: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state_out    = r_gen;
    assign steps        = r_steps;
    assign busy         = (r_state == ST_RUN);
    assign done         = (r_state == ST_DONE);
    assign done_cycle   = r_done_cycle;
    assign done_timeout = r_done_timeout;

endmodule

// File: tb/tb_ca_stepper.sv
// Directed bench for ca_stepper: driver queues hand-computed post-edge
// expectations, a monitor pops and compares them after every rising edge.
module tb_ca_stepper;

    localparam int W  = 8;
    localparam int MS = 20;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [W-1:0] seed = '0;
    logic [7:0]   rule = '0;
    logic         cycle_in;
    logic [W-1:0] state_out;
    logic         busy, done, done_cycle, done_timeout;
    logic [7:0]   steps;

    logic         drv_cyc = 1'b0;
    logic         closed = 1'b0;
    logic         chk_cyc;
    logic [W-1:0] chk_prev;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] st;
        logic [7:0] steps;
        logic       busy, done, dc, dt;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    ca_stepper #(.WIDTH(W), .MAX_STEPS(MS), .CNT_W(8)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .load         (load),
        .seed         (seed),
        .rule         (rule),
        .start        (start),
        .stop         (stop),
        .cycle_in     (cycle_in),
        .state_out    (state_out),
        .busy         (busy),
        .done         (done),
        .done_cycle   (done_cycle),
        .done_timeout (done_timeout),
        .steps        (steps)
    );

    // Minimal stand-in for the downstream checker: flags a generation equal
    // to the previous one, one edge late.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            chk_prev <= '0;
            chk_cyc  <= 1'b0;
        end else begin
            chk_prev <= state_out;
            chk_cyc  <= (state_out == chk_prev);
        end
    end

    assign cycle_in = closed ? chk_cyc : drv_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] st, input logic [7:0] sp,
                                input logic b, input logic d, input logic dc, input logic dt);
        exp_t e;
        e.st = st; e.steps = sp; e.busy = b; e.done = d; e.dc = dc; e.dt = dt;
        return e;
    endfunction

    task automatic step(input logic ld, input logic [7:0] sd, input logic [7:0] rl,
                        input logic sta, input logic sto, input logic cyc, input exp_t e);
        load = ld; seed = sd; rule = rl; start = sta; stop = sto; drv_cyc = cyc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_step(input exp_t e);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, state_out, 0);
        chk({tag, "_steps"}, steps, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dcyc"}, done_cycle, 0);
        chk({tag, "_dto"}, done_timeout, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state_out", state_out, e.st);
                chk("steps", steps, e.steps);
                chk("busy", busy, e.busy);
                chk("done", done, e.done);
                chk("done_cycle", done_cycle, e.dc);
                chk("done_timeout", done_timeout, e.dt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        // Identity rule 0xCC: generation holds, counter climbs
        step(1, 8'h5A, 8'hCC, 0, 0, 0, mk(8'h5A, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'h5A, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            idle_step(mk(8'h5A, 8'(k), 1, 0, 0, 0));

        // Stop at 5, hold, start+stop ignored, resume to 6
        step(0, 8'h00, 8'h00, 0, 1, 0, mk(8'h5A, 5, 0, 0, 0, 0));
        idle_step(mk(8'h5A, 5, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 1, 0, mk(8'h5A, 5, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'h5A, 5, 1, 0, 0, 0));
        idle_step(mk(8'h5A, 6, 1, 0, 0, 0));

        // Rule 0xAA rotates left; timeout after MS generations
        step(1, 8'h01, 8'hAA, 0, 0, 0, mk(8'h01, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'h01, 0, 1, 0, 0, 0));
        for (int k = 1; k <= MS; k++)
            idle_step(mk(8'(1 << (k % 8)), 8'(k), 1, 0, 0, 0));
        idle_step(mk(8'h10, 8'(MS), 0, 1, 0, 1));
        step(0, 8'h00, 8'h00, 1, 1, 1, mk(8'h10, 8'(MS), 0, 1, 0, 1));

        // Rule 0x33 inverts; cycle_in honoured only once steps reaches 3
        step(1, 8'h5A, 8'h33, 0, 0, 1, mk(8'h5A, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 1, mk(8'h5A, 0, 1, 0, 0, 0));
        step(0, 8'h00, 8'h00, 0, 0, 1, mk(8'hA5, 1, 1, 0, 0, 0));
        step(0, 8'h00, 8'h00, 0, 0, 1, mk(8'h5A, 2, 1, 0, 0, 0));
        step(0, 8'h00, 8'h00, 0, 0, 1, mk(8'hA5, 3, 1, 0, 0, 0));
        step(0, 8'h00, 8'h00, 0, 0, 1, mk(8'hA5, 3, 0, 1, 1, 0));
        step(0, 8'h00, 8'h00, 1, 0, 1, mk(8'hA5, 3, 0, 1, 1, 0));

        // Load beats stop and cycle_in while running
        step(1, 8'h5A, 8'hCC, 0, 0, 0, mk(8'h5A, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'h5A, 0, 1, 0, 0, 0));
        idle_step(mk(8'h5A, 1, 1, 0, 0, 0));
        step(1, 8'hC3, 8'hCC, 0, 1, 1, mk(8'hC3, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'hC3, 0, 1, 0, 0, 0));
        idle_step(mk(8'hC3, 1, 1, 0, 0, 0));

        // Asynchronous reset mid-run, sampled before the next edge
        n_reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        n_reset = 1'b1;

        // Closed loop with rule 0: fixed point at zero
        closed = 1'b1;
        step(1, 8'h00, 8'h00, 0, 0, 0, mk(8'h00, 0, 0, 0, 0, 0));
        step(0, 8'h00, 8'h00, 1, 0, 0, mk(8'h00, 0, 1, 0, 0, 0));
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++)
            @(negedge clk);
        chk("cl_done", done, 1);
        chk("cl_done_cycle", done_cycle, 1);
        chk("cl_done_timeout", done_timeout, 0);
        chk("cl_steps_le5", (steps <= 8'd5) ? 1 : 0, 1);
        chk("cl_steps_ge3", (steps >= 8'd3) ? 1 : 0, 1);
        chk("cl_state", state_out, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
